sram_read_scheduler: RTL and testbench
======================================

Name: sram_read_scheduler

Overview:
- Request-side front end that sits directly upstream of the 16-bank SRAM cluster.
- Accepts read lookups from two pipeline requesters and drives one read enable and address per bank.
- Arbitrates bank conflicts round-robin, captures the bank's 1-cycle-latency read data, and returns it with the request tag.
- Each port has a credit-protected response FIFO with valid/ready backpressure.

Parameters:
- NUM_BANKS, 16, number of SRAM banks in the cluster (bank index width BANK_W = 4).
- ADDR_W, 8, row address width per bank.
- DATA_W, 64, read data width per bank.
- TAG_W, 4, requester tag width, returned unmodified.
- RESP_DEPTH, 4, response FIFO depth per port; also the credit limit per port.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid (bit p = port p).
- req_ready  out  2  per-port request accepted this cycle.
- req_addr  in  2*(BANK_W+ADDR_W)  per port: [11:8] bank, [7:0] row; port p at slice p.
- req_tag  in  2*TAG_W  per-port tag.
- sram_r_en  out  NUM_BANKS  per-bank read enable to the cluster.
- sram_r_addr  out  NUM_BANKS*ADDR_W  per-bank row address; bank b at slice b.
- sram_r_data  in  NUM_BANKS*DATA_W  per-bank read data, valid one cycle after sram_r_en.
- resp_valid  out  2  per-port response valid.
- resp_ready  in  2  per-port response ready.
- resp_data  out  2*DATA_W  per-port read data.
- resp_tag  out  2*TAG_W  per-port tag.

Behaviour:
- Reset (reset=0, asynchronous):
  - clears both FIFOs, in-flight registers, and rr_ptr (rr_ptr=0).
  - resp_valid=0, req_ready=0, sram_r_en=0, sram_r_addr=0 while asserted.
- Credits per port:
  - credit_p = RESP_DEPTH - fifo_count_p - inflight_p.
  - credit_p > 0 is required for acceptance, so no FIFO overflow is possible.
- Conflict: both req_valid set, both ports have credit, and bank fields are equal (rows irrelevant; single read port per bank).
- Grant:
  - port p is granted iff req_valid_p and credit_p>0 and (no conflict, or rr_ptr==p).
  - req_ready_p = credit_p>0 and not (conflict and rr_ptr!=p). req_ready may depend combinationally on the other port's valid and address.
- rr_ptr: on a conflict cycle, rr_ptr toggles to the losing port; otherwise unchanged.
- Bank drive (combinational in acceptance cycle T):
  - granted bank: sram_r_en[b]=1, sram_r_addr[b]=row.
  - all other banks: r_en=0, addr=0.
  - two grants always target distinct banks.
- In-flight stage (registered at end of T): inflight_p, bank_p, tag_p.
- Capture (cycle T+1):
  - if inflight_p, push {sram_r_data[bank_p], tag_p} into FIFO_p.
  - inflight_p clears unless a new grant occurs in T+1. Back-to-back acceptance every cycle is supported while credit allows.
- FIFO_p output:
  - resp_valid_p = not empty.
  - pop on resp_valid_p & resp_ready_p.
  - push and pop in the same cycle are both honoured.
  - no bypass: minimum latency is acceptance in T to resp_valid in T+2.
- Ordering: responses within a port return in acceptance order. There is no ordering relation between ports.
- Stall: resp_ready_p held low makes FIFO_p fill. After RESP_DEPTH outstanding (FIFO plus in-flight), req_ready_p=0 until a pop. The other port is unaffected.
- Reset mid-operation drops all in-flight and queued responses; no partial response is emitted after reset release.

Test Plan:
- Single read: port0 addr=0x3A5, tag=5, resp_ready=1.
  - Expected: cycle T sram_r_en=0x0008, sram_r_addr[3]=0xA5.
  - Expected: T+1 bench drives sram_r_data[3]=0xDEADBEEF_00000001.
  - Expected: T+2 resp_valid[0]=1, resp_data matches, resp_tag=5.
- No conflict: port0 bank2, port1 bank7, same cycle.
  - Expected: both req_ready=1, sram_r_en=0x0084, both responses arrive at T+2, rr_ptr unchanged.
- Conflict rotation: both ports bank 9, held valid for 4 cycles after reset.
  - Expected grant sequence: port0, port1, port0, port1.
  - Expected: never two enables for bank 9; each port gets 2 responses in order.
- Backpressure on port1 (resp_ready[1]=0, continuous requests):
  - Expected: exactly 4 accepted, then req_ready[1]=0.
  - Expected: one pop restores one acceptance.
  - Expected: port0 throughput stays 1 per cycle throughout.
- Simultaneous push/pop: full FIFO with resp_ready=1 and a new request each cycle.
  - Expected: steady-state 1 response per cycle, count stays bounded, no loss or duplication (tags checked 0..15 wrap).
- Async reset asserted while 3 responses are queued and 1 is in flight.
  - Expected: resp_valid drops immediately.
  - Expected: after release, no stale response appears and credit is back to 4.

Source files
------------

// File: rtl/sram_read_scheduler.sv
// sram_read_scheduler
//   Front end for a banked SRAM cluster. Two requesters issue read lookups
//   ({bank, row} address plus a tag). The scheduler drives one read enable
//   and row address per bank, picks a winner round-robin when both ports
//   target the same bank, captures the bank's data one cycle later and
//   returns it with the original tag through a per-port response FIFO.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both 1. req_ready_o may depend combinationally on the other port's
//   valid and bank; resp_valid_o never depends on resp_ready_i.
//
// Ports
//   clock_i        single clock, all state on rising edge
//   reset_ni       asynchronous active-low reset
//   req_valid_i    [2]            per-port request valid
//   req_ready_o    [2]            per-port request accepted this cycle
//   req_addr_i     [2*(BANK_W+ADDR_W)] per port {bank, row}, port p at slice p
//   req_tag_i      [2*TAG_W]      per-port tag
//   sram_r_en_o    [NUM_BANKS]    per-bank read enable
//   sram_r_addr_o  [NUM_BANKS*ADDR_W] per-bank row address, bank b at slice b
//   sram_r_data_i  [NUM_BANKS*DATA_W] per-bank read data, one cycle after enable
//   resp_valid_o   [2]            per-port response valid
//   resp_ready_i   [2]            per-port response ready
//   resp_data_o    [2*DATA_W]     per-port read data
//   resp_tag_o     [2*TAG_W]      per-port tag
module sram_read_scheduler #(
  parameter int NUM_BANKS  = 16,
  parameter int BANK_W     = $clog2(NUM_BANKS),
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 64,
  parameter int TAG_W      = 4,
  parameter int RESP_DEPTH = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic [1:0]                    req_valid_i,
  output logic [1:0]                    req_ready_o,
  input  logic [2*(BANK_W+ADDR_W)-1:0]  req_addr_i,
  input  logic [2*TAG_W-1:0]            req_tag_i,
  output logic [NUM_BANKS-1:0]          sram_r_en_o,
  output logic [NUM_BANKS*ADDR_W-1:0]   sram_r_addr_o,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_r_data_i,
  output logic [1:0]                    resp_valid_o,
  input  logic [1:0]                    resp_ready_i,
  output logic [2*DATA_W-1:0]           resp_data_o,
  output logic [2*TAG_W-1:0]            resp_tag_o
);

  localparam int REQ_W = BANK_W + ADDR_W;
  localparam int ENT_W = DATA_W + TAG_W;
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  // ---------------------------------------------------------------------
  // Request field decode
  // ---------------------------------------------------------------------
  logic [BANK_W-1:0] req_bank [2];
  logic [ADDR_W-1:0] req_row  [2];
  logic [TAG_W-1:0]  req_tag  [2];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_bank[p] = req_addr_i[p*REQ_W+ADDR_W +: BANK_W];
      req_row[p]  = req_addr_i[p*REQ_W +: ADDR_W];
      req_tag[p]  = req_tag_i[p*TAG_W +: TAG_W];
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]  count_q    [2];
  logic [CNT_W-1:0]  count_d    [2];
  logic [PTR_W-1:0]  wr_ptr_q   [2];
  logic [PTR_W-1:0]  wr_ptr_d   [2];
  logic [PTR_W-1:0]  rd_ptr_q   [2];
  logic [PTR_W-1:0]  rd_ptr_d   [2];
  logic [1:0]        inflight_q;
  logic [1:0]        inflight_d;
  logic [BANK_W-1:0] bank_q     [2];
  logic [BANK_W-1:0] bank_d     [2];
  logic [TAG_W-1:0]  tag_q      [2];
  logic [TAG_W-1:0]  tag_d      [2];
  logic              rr_ptr_q;
  logic              rr_ptr_d;
  logic [ENT_W-1:0]  mem_q      [2][RESP_DEPTH];

  // ---------------------------------------------------------------------
  // Credit and arbitration
  // ---------------------------------------------------------------------
  logic [1:0]       has_credit;
  logic             conflict;
  logic [1:0]       grant;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [ENT_W-1:0] push_ent [2];

  // Credit counts both queued entries and the read that is still in the
  // SRAM pipeline, so an accepted request always has a FIFO slot waiting.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      has_credit[p] = ({1'b0, count_q[p]} + (CNT_W+1)'(inflight_q[p]))
                      < (CNT_W+1)'(RESP_DEPTH);
    end
  end

  // A conflict only exists when both ports could actually be granted;
  // if one lacks credit the other proceeds and rr_ptr stays put.
  assign conflict = (&req_valid_i) && (&has_credit) && (req_bank[0] == req_bank[1]);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      req_ready_o[p] = reset_ni && has_credit[p] && !(conflict && (rr_ptr_q != 1'(p)));
    end
  end

  assign grant    = req_valid_i & req_ready_o;
  assign rr_ptr_d = conflict ? ~rr_ptr_q : rr_ptr_q;

  // ---------------------------------------------------------------------
  // Bank drive: grants never share a bank, so at most one port writes
  // each bank's enable/address in a given cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    sram_r_en_o   = '0;
    sram_r_addr_o = '0;
    for (int p = 0; p < 2; p++) begin
      if (grant[p]) begin
        sram_r_en_o[req_bank[p]] = 1'b1;
        sram_r_addr_o[int'(req_bank[p])*ADDR_W +: ADDR_W] = req_row[p];
      end
    end
  end

  // ---------------------------------------------------------------------
  // In-flight stage and capture
  // ---------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(RESP_DEPTH - 1)) return '0;
    return ptr + 1'b1;
  endfunction

  always_comb begin
    inflight_d = grant;
    for (int p = 0; p < 2; p++) begin
      bank_d[p]   = grant[p] ? req_bank[p] : bank_q[p];
      tag_d[p]    = grant[p] ? req_tag[p]  : tag_q[p];
      push[p]     = inflight_q[p];
      push_ent[p] = {sram_r_data_i[int'(bank_q[p])*DATA_W +: DATA_W], tag_q[p]};
      pop[p]      = (count_q[p] != '0) && resp_ready_i[p];
      count_d[p]  = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      wr_ptr_d[p] = push[p] ? ptr_inc(wr_ptr_q[p]) : wr_ptr_q[p];
      rd_ptr_d[p] = pop[p]  ? ptr_inc(rd_ptr_q[p]) : rd_ptr_q[p];
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      inflight_q <= '0;
      rr_ptr_q   <= 1'b0;
      for (int p = 0; p < 2; p++) begin
        count_q[p]  <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        bank_q[p]   <= '0;
        tag_q[p]    <= '0;
      end
    end else begin
      inflight_q <= inflight_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int p = 0; p < 2; p++) begin
        count_q[p]  <= count_d[p];
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        bank_q[p]   <= bank_d[p];
        tag_q[p]    <= tag_d[p];
      end
    end
  end

  // FIFO storage carries no reset: an entry is only visible once count_q
  // covers it, and count_q is cleared asynchronously.
  always_ff @(posedge clock_i) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= push_ent[p];
    end
  end

  // ---------------------------------------------------------------------
  // Response outputs (registered FIFO head, no bypass)
  // ---------------------------------------------------------------------
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      resp_valid_o[p]                    = (count_q[p] != '0);
      resp_data_o[p*DATA_W +: DATA_W]    = mem_q[p][rd_ptr_q[p]][ENT_W-1:TAG_W];
      resp_tag_o[p*TAG_W +: TAG_W]       = mem_q[p][rd_ptr_q[p]][TAG_W-1:0];
    end
  end

endmodule

// File: tb/tb_sram_read_scheduler.sv
module tb_sram_read_scheduler;

  localparam int NB = 16;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int TW = 4;
  localparam int RW = 12;
  localparam int EW = DW + TW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [2*RW-1:0]  req_addr;
  logic [2*TW-1:0]  req_tag;
  logic [NB-1:0]    sram_r_en;
  logic [NB*AW-1:0] sram_r_addr;
  logic [NB*DW-1:0] sram_r_data;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [2*DW-1:0]  resp_data;
  logic [2*TW-1:0]  resp_tag;

  sram_read_scheduler dut (
    .clock_i       (clk),
    .reset_ni      (rst_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_addr_i    (req_addr),
    .req_tag_i     (req_tag),
    .sram_r_en_o   (sram_r_en),
    .sram_r_addr_o (sram_r_addr),
    .sram_r_data_i (sram_r_data),
    .resp_valid_o  (resp_valid),
    .resp_ready_i  (resp_ready),
    .resp_data_o   (resp_data),
    .resp_tag_o    (resp_tag)
  );

  // ---------------- SRAM model ----------------
  // Enabled banks return mem contents one cycle later; idle banks return
  // noise so a capture from the wrong bank shows up as a data error.
  logic [DW-1:0] mem [NB][256];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (sram_r_en[b]) sram_r_data[b*DW +: DW] <= mem[b][sram_r_addr[b*AW +: AW]];
      else              sram_r_data[b*DW +: DW] <= {$urandom, $urandom};
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [1:0]    pend_v;
  logic [EW-1:0] pend_d [2];
  logic          rr_m;

  int tests = 0;
  int fails = 0;
  int obs_acc [2];
  int obs_pop [2];

  logic [1:0]       snap_rdy;
  logic [NB-1:0]    snap_en;
  logic [NB*AW-1:0] snap_addr;
  logic [1:0]       snap_rv;
  logic [DW-1:0]    snap_data0;
  logic [TW-1:0]    snap_tag0;

  task automatic chk(input string name, input logic [NB*AW-1:0] obs, input logic [NB*AW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int q_size(input int p);
    return (p == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [EW-1:0] q_front(input int p);
    return (p == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int p, input logic v, input logic [RW-1:0] a, input logic [TW-1:0] t);
    req_valid[p]           = v;
    req_addr[p*RW +: RW]   = a;
    req_tag[p*TW +: TW]    = t;
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    pend_v = 2'b00;
    rr_m   = 1'b0;
  endtask

  // One clock cycle. Called just after a rising edge with inputs already
  // driven; checks outputs at the falling edge, then advances the model.
  task automatic cycle();
    logic [1:0]       credit, rdy, gnt, pop_m;
    logic             conflict;
    logic [NB-1:0]    en;
    logic [NB*AW-1:0] addr;
    logic [3:0]       bk [2];
    logic [AW-1:0]    row [2];
    logic [EW-1:0]    f;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      bk[p]     = req_addr[p*RW+AW +: 4];
      row[p]    = req_addr[p*RW +: AW];
      credit[p] = (q_size(p) + int'(pend_v[p])) < 4;
    end
    conflict = (&req_valid) && (&credit) && (bk[0] == bk[1]);
    en   = '0;
    addr = '0;
    for (int p = 0; p < 2; p++) begin
      rdy[p] = credit[p] && !(conflict && (rr_m != 1'(p)));
      gnt[p] = rdy[p] && req_valid[p];
      if (gnt[p]) begin
        en[bk[p]] = 1'b1;
        addr[int'(bk[p])*AW +: AW] = row[p];
      end
    end
    chk("req_ready", {126'd0, req_ready}, {126'd0, rdy});
    chk("sram_r_en", {112'd0, sram_r_en}, {112'd0, en});
    chk("sram_r_addr", sram_r_addr, addr);
    for (int p = 0; p < 2; p++) begin
      pop_m[p] = (q_size(p) > 0) && resp_ready[p];
      if (q_size(p) > 0) begin
        f = q_front(p);
        chk("resp_valid", {127'd0, resp_valid[p]}, 128'd1);
        chk("resp_data", {64'd0, resp_data[p*DW +: DW]}, {64'd0, f[EW-1:TW]});
        chk("resp_tag", {124'd0, resp_tag[p*TW +: TW]}, {124'd0, f[TW-1:0]});
      end else begin
        chk("resp_idle", {127'd0, resp_valid[p]}, 128'd0);
      end
      if (req_valid[p] && req_ready[p]) obs_acc[p]++;
      if (resp_valid[p] && resp_ready[p]) obs_pop[p]++;
    end
    snap_rdy   = req_ready;
    snap_en    = sram_r_en;
    snap_addr  = sram_r_addr;
    snap_rv    = resp_valid;
    snap_data0 = resp_data[DW-1:0];
    snap_tag0  = resp_tag[TW-1:0];
    @(posedge clk);
    #1;
    if (pop_m[0]) void'(exp_q0.pop_front());
    if (pop_m[1]) void'(exp_q1.pop_front());
    if (pend_v[0]) exp_q0.push_back(pend_d[0]);
    if (pend_v[1]) exp_q1.push_back(pend_d[1]);
    for (int p = 0; p < 2; p++) begin
      pend_v[p] = gnt[p];
      if (gnt[p]) pend_d[p] = {mem[bk[p]][row[p]], req_tag[p*TW +: TW]};
    end
    if (conflict) rr_m = ~rr_m;
  endtask

  task automatic reset_counts();
    obs_acc[0] = 0; obs_acc[1] = 0;
    obs_pop[0] = 0; obs_pop[1] = 0;
  endtask

  task automatic drain();
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    repeat (8) cycle();
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0] rot [4];

  initial begin
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < 256; r++) mem[b][r] = {$urandom, $urandom};
    mem[3][8'hA5] = 64'hDEADBEEF_00000001;
    rst_n = 1'b0;
    req_valid = 2'b00; req_addr = '0; req_tag = '0; resp_ready = 2'b00;
    clear_model();
    reset_counts();
    set_req(0, 1'b1, 12'h100, 4'd1);
    set_req(1, 1'b1, 12'h200, 4'd2);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", {126'd0, resp_valid}, 128'd0);
    chk("rst_req_ready", {126'd0, req_ready}, 128'd0);
    chk("rst_r_en", {112'd0, sram_r_en}, 128'd0);
    chk("rst_r_addr", sram_r_addr, 128'd0);
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read
    resp_ready = 2'b11;
    set_req(0, 1'b1, 12'h3A5, 4'd5);
    cycle();
    chk("t1_en", {112'd0, snap_en}, 128'h0008);
    chk("t1_addr", {120'd0, snap_addr[3*AW +: AW]}, 128'hA5);
    req_valid = 2'b00;
    cycle();
    chk("t1_t1_valid", {127'd0, snap_rv[0]}, 128'd0);
    cycle();
    chk("t1_t2_valid", {127'd0, snap_rv[0]}, 128'd1);
    chk("t1_data", {64'd0, snap_data0}, {64'd0, 64'hDEADBEEF_00000001});
    chk("t1_tag", {124'd0, snap_tag0}, 128'd5);
    drain();

    // No conflict
    set_req(0, 1'b1, 12'h211, 4'd3);
    set_req(1, 1'b1, 12'h722, 4'd4);
    cycle();
    chk("t2_ready", {126'd0, snap_rdy}, 128'd3);
    chk("t2_en", {112'd0, snap_en}, 128'h0084);
    req_valid = 2'b00;
    cycle();
    cycle();
    chk("t2_both_valid", {126'd0, snap_rv}, 128'd3);
    drain();

    // Conflict rotation on bank 9 (rr_ptr still at port 0)
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, {4'h9, 8'(i)},        4'(i));
      set_req(1, 1'b1, {4'h9, 8'(8'h80 + i)}, 4'(8 + i));
      cycle();
      rot[i] = snap_rdy;
    end
    chk("t3_rot0", {126'd0, rot[0]}, 128'd1);
    chk("t3_rot1", {126'd0, rot[1]}, 128'd2);
    chk("t3_rot2", {126'd0, rot[2]}, 128'd1);
    chk("t3_rot3", {126'd0, rot[3]}, 128'd2);
    drain();

    // Backpressure on port 1
    resp_ready = 2'b01;
    reset_counts();
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, {4'h1, 8'(i)}, 4'(i));
      set_req(1, 1'b1, {4'h5, 8'(i)}, 4'(i));
      cycle();
    end
    chk("t4_p1_accepts", 128'(obs_acc[1]), 128'd4);
    chk("t4_p0_accepts", 128'(obs_acc[0]), 128'd8);
    reset_counts();
    resp_ready = 2'b11;
    cycle();
    resp_ready = 2'b01;
    repeat (3) cycle();
    chk("t4_one_pop_one_accept", 128'(obs_acc[1]), 128'd1);
    chk("t4_p0_thru", 128'(obs_acc[0]), 128'd4);
    drain();

    // Simultaneous push/pop on a full FIFO
    resp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, {4'hB, 8'(i)}, 4'(12 + i));
      cycle();
    end
    resp_ready = 2'b01;
    reset_counts();
    for (int i = 0; i < 16; i++) begin
      set_req(0, 1'b1, {4'hB, 8'(8'h40 + i)}, 4'(i));
      cycle();
    end
    chk("t5_accepts", 128'(obs_acc[0]), 128'd15);
    chk("t5_pops", 128'(obs_pop[0]), 128'd16);
    drain();

    // Async reset with 3 queued and 1 in flight
    resp_ready = 2'b00;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, {4'hC, 8'(i)}, 4'(i));
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_resp_valid_drop", {126'd0, resp_valid}, 128'd0);
    chk("t6_req_ready_drop", {126'd0, req_ready}, 128'd0);
    chk("t6_r_en_drop", {112'd0, sram_r_en}, 128'd0);
    clear_model();
    req_valid = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 2'b11;
    repeat (3) cycle();
    resp_ready = 2'b00;
    reset_counts();
    for (int i = 0; i < 6; i++) begin
      set_req(0, 1'b1, {4'hD, 8'(i)}, 4'(i));
      cycle();
    end
    chk("t6_credit_restored", 128'(obs_acc[0]), 128'd4);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
